jesd_link_supervisor: RTL and testbench
=======================================

Name: jesd_link_supervisor

Overview:
- Sequences and monitors up to NUM_LINKS ADC lane-alignment blocks on one ADC JESD204B link.
- Generates the local LMFC edge, phase-aligned to SYSREF.
- Drives each aligner's reset, combines their SYNC~ requests toward the ADC, watches alignment completion and 8b/10b errors, and re-sequences the link on timeout or error burst, with bounded retries.

Parameters:
NUM_LINKS, 2, number of aligner instances supervised
LMFC_PERIOD, 16, clk cycles per multiframe (2..256)
SYSREF_REQ, 1, 1 = wait for a SYSREF rising edge before the first sequence; 0 = skip WAIT_SYSREF
RST_CYCLES, 4, cycles link_rst is held high in RESET_LINKS
TIMEOUT, 1048576, max cycles allowed in each of WAIT_SYNC and WAIT_ALIGN
ERR_WINDOW, 4096, error observation window in cycles
ERR_THRESH, 8, error cycles per window that trigger a resync
MAX_RETRY, 15, resync attempts before FAULT

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run the link; low forces IDLE
sysref  in  1  SYSREF, already synchronous to clk
link_sync_n  in  NUM_LINKS  per-aligner SYNC~ (high = code-group sync done)
link_aligned  in  NUM_LINKS  per-aligner one-cycle pulse at lane alignment
link_err  in  NUM_LINKS  per-aligner OR of disparity/not-in-table errors, per cycle
lmfc_edge  out  1  one-cycle LMFC pulse to all aligners
link_rst  out  NUM_LINKS  per-aligner reset
sync_n_out  out  1  combined SYNC~ to ADC
linked  out  1  high in RUN
fault  out  1  sticky retry-exhausted flag
sysref_err  out  1  sticky flag: SYSREF edge off LMFC phase
retry_cnt  out  4  resync attempts since enable
state  out  3  IDLE=0, WAIT_SYSREF=1, RESET_LINKS=2, WAIT_SYNC=3, WAIT_ALIGN=4, RUN=5, FAULT=6

Behaviour:
- Reset values:
  - state=IDLE, link_rst=all 1, sync_n_out=1, linked=0, fault=0, sysref_err=0, retry_cnt=0, lmfc_edge=0.
  - LMFC counter cnt=0; all internal counters and the aligned_seen latches are 0.
- LMFC generation:
  - sysref_q is sysref registered; rise = sysref & ~sysref_q.
  - Each cycle, cnt <= 0 if rise or cnt==LMFC_PERIOD-1; otherwise cnt+1.
  - lmfc_edge is registered: lmfc_edge <= rise | (cnt==LMFC_PERIOD-1). It is therefore high exactly in the cycles where cnt==0.
  - The LMFC counter runs free in every state.
- SYSREF phase check: a rise with cnt != LMFC_PERIOD-1, outside WAIT_SYSREF, sets sysref_err. sysref_err is cleared only by rst or by enable low.
- enable low, from any state:
  - Next cycle state=IDLE, link_rst=all 1, retry_cnt=0, fault=0, sysref_err=0.
- State transitions:
  - IDLE: when enable=1, go to WAIT_SYSREF if SYSREF_REQ=1, else RESET_LINKS.
  - WAIT_SYSREF: on rise, go to RESET_LINKS. No timeout.
  - RESET_LINKS:
    - link_rst=all 1 for RST_CYCLES cycles; sync_n_out forced 0; aligned_seen cleared; error and timeout counters cleared.
    - Then go to WAIT_SYNC, with link_rst=0 from the first cycle of WAIT_SYNC.
  - WAIT_SYNC:
    - sync_n_out <= AND(link_sync_n), registered.
    - When all link_sync_n are high, go to WAIT_ALIGN.
    - After TIMEOUT cycles without that, resync.
  - WAIT_ALIGN:
    - Each link_aligned pulse sets aligned_seen[i].
    - When all bits are set, go to RUN. A pulse arriving in the completing cycle counts.
    - After TIMEOUT cycles without that, or if any link_sync_n goes low, resync.
  - RUN:
    - linked=1 and sync_n_out <= AND(link_sync_n).
    - Window counter wraps every ERR_WINDOW cycles. err_cnt increments, saturating, on each cycle with any link_err bit set; err_cnt clears at window wrap.
    - Resync when the incremented err_cnt reaches ERR_THRESH. This comparison takes priority over a wrap in the same cycle.
    - Also resync if any link_sync_n goes low.
  - Resync: if retry_cnt==MAX_RETRY, go to FAULT; otherwise retry_cnt+1 and go to RESET_LINKS. WAIT_SYSREF is not re-entered.
  - FAULT: fault=1, link_rst=all 1, sync_n_out=1. Held until enable low or rst.
- Priority within a cycle: a success condition beats a timeout in the same cycle; enable low beats everything except rst.
- retry_cnt saturates at MAX_RETRY and is not cleared by a successful RUN.
- Timeout counters: restart on each state entry and count only in their own state.

Test Plan:
- Reset with enable=0 -> link_rst=11, sync_n_out=1, state=0. lmfc_edge pulses with 16-cycle spacing, first pulse 16 cycles after reset release.
- enable=1, SYSREF rise at cycle 37 -> lmfc_edge at cycle 38 and every 16 cycles after. state goes 1->2. link_rst=11 for 4 cycles; sync_n_out=0 during RESET_LINKS.
- link_sync_n=11, then link_aligned[0] at t and link_aligned[1] at t+5 -> RUN entered at t+6, linked=1, retry_cnt=0.
- In RUN, link_err=01 for 8 cycles within one 4096-cycle window -> resync to RESET_LINKS, retry_cnt=1. Seven error cycles, a wrap, then seven more -> no resync.
- Hold link_sync_n=00 (TIMEOUT set to 64) -> 16 timeouts give retry_cnt=15, then state=6, fault=1, link_rst=11. Driving enable low for one cycle -> IDLE, fault=0, retry_cnt=0.
- In RUN, SYSREF rise at cnt=5 -> sysref_err=1 while the link stays linked. A rise at cnt=15 leaves sysref_err unchanged.

Source files
------------

// File: rtl/jesd_link_supervisor.sv
// JESD204B ADC link supervisor: LMFC generation aligned to SYSREF, aligner reset
// sequencing, SYNC~ combining, alignment/error monitoring and bounded resync.
module jesd_link_supervisor #(
    parameter int unsigned NUM_LINKS   = 2,
    parameter int unsigned LMFC_PERIOD = 16,
    parameter bit          SYSREF_REQ  = 1'b1,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned TIMEOUT     = 1048576,
    parameter int unsigned ERR_WINDOW  = 4096,
    parameter int unsigned ERR_THRESH  = 8,
    parameter int unsigned MAX_RETRY   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 sysref_i,
    input  logic [NUM_LINKS-1:0] link_sync_n_i,
    input  logic [NUM_LINKS-1:0] link_aligned_i,
    input  logic [NUM_LINKS-1:0] link_err_i,
    output logic                 lmfc_edge_o,
    output logic [NUM_LINKS-1:0] link_rst_o,
    output logic                 sync_n_out_o,
    output logic                 linked_o,
    output logic                 fault_o,
    output logic                 sysref_err_o,
    output logic [3:0]           retry_cnt_o,
    output logic [2:0]           state_o
);

    localparam int unsigned CW = (LMFC_PERIOD > 1) ? $clog2(LMFC_PERIOD) : 1;
    localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned WW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int unsigned EW = $clog2(ERR_THRESH + 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_SYSREF = 3'd1,
        S_RESET_LINKS = 3'd2,
        S_WAIT_SYNC   = 3'd3,
        S_WAIT_ALIGN  = 3'd4,
        S_RUN         = 3'd5,
        S_FAULT       = 3'd6
    } state_t;

    state_t               state_q;
    logic                 sysref_q, lmfc_q, sync_n_q, linked_q, fault_q, sysref_err_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [RW-1:0]        rst_cnt_q;
    logic [TW-1:0]        to_cnt_q;
    logic [WW-1:0]        win_cnt_q;
    logic [EW-1:0]        err_cnt_q, err_cnt_d;
    logic [NUM_LINKS-1:0] seen_q, seen_d, link_rst_q;
    logic [3:0]           retry_q;

    logic rise, lmfc_last, sync_all, to_hit, err_trip, win_wrap, resync, retry_max, enter_rst;

    always_comb begin
        rise      = sysref_i & ~sysref_q;
        lmfc_last = (cnt_q == CW'(LMFC_PERIOD - 1));
        cnt_d     = (rise || lmfc_last) ? '0 : cnt_q + 1'b1;
        sync_all  = &link_sync_n_i;
        seen_d    = seen_q | link_aligned_i;
        to_hit    = (to_cnt_q == TW'(TIMEOUT - 1));
        win_wrap  = (win_cnt_q == WW'(ERR_WINDOW - 1));
        err_cnt_d = err_cnt_q;
        if (|link_err_i && err_cnt_q != EW'(ERR_THRESH))
            err_cnt_d = err_cnt_q + 1'b1;
        // threshold is judged on the incremented count, ahead of any window wrap
        err_trip  = |link_err_i && (err_cnt_d == EW'(ERR_THRESH));
        retry_max = (retry_q == 4'(MAX_RETRY));
        resync    = 1'b0;
        case (state_q)
            S_WAIT_SYNC:  resync = !sync_all && to_hit;
            S_WAIT_ALIGN: resync = !(&seen_d) && (to_hit || !sync_all);
            S_RUN:        resync = err_trip || !sync_all;
            default:      resync = 1'b0;
        endcase
        enter_rst = (state_q == S_IDLE && !SYSREF_REQ)
                 || (state_q == S_WAIT_SYSREF && rise)
                 || (resync && !retry_max);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sysref_q     <= 1'b0;
            cnt_q        <= '0;
            lmfc_q       <= 1'b0;
            link_rst_q   <= '1;
            sync_n_q     <= 1'b1;
            linked_q     <= 1'b0;
            fault_q      <= 1'b0;
            sysref_err_q <= 1'b0;
            retry_q      <= '0;
            rst_cnt_q    <= '0;
            to_cnt_q     <= '0;
            win_cnt_q    <= '0;
            err_cnt_q    <= '0;
            seen_q       <= '0;
        end else begin
            sysref_q <= sysref_i;
            cnt_q    <= cnt_d;
            lmfc_q   <= rise | lmfc_last;
            if (!enable_i) begin
                state_q      <= S_IDLE;
                link_rst_q   <= '1;
                sync_n_q     <= 1'b1;
                linked_q     <= 1'b0;
                fault_q      <= 1'b0;
                sysref_err_q <= 1'b0;
                retry_q      <= '0;
                rst_cnt_q    <= '0;
                to_cnt_q     <= '0;
                win_cnt_q    <= '0;
                err_cnt_q    <= '0;
                seen_q       <= '0;
            end else begin
                if (rise && !lmfc_last && state_q != S_WAIT_SYSREF)
                    sysref_err_q <= 1'b1;
                case (state_q)
                    S_IDLE: if (SYSREF_REQ) state_q <= S_WAIT_SYSREF;
                    S_WAIT_SYSREF: ;
                    S_RESET_LINKS: begin
                        if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                            state_q    <= S_WAIT_SYNC;
                            link_rst_q <= '0;
                            to_cnt_q   <= '0;
                        end else begin
                            rst_cnt_q <= rst_cnt_q + 1'b1;
                        end
                    end
                    S_WAIT_SYNC: begin
                        sync_n_q <= sync_all;
                        if (sync_all) begin
                            state_q  <= S_WAIT_ALIGN;
                            to_cnt_q <= '0;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    S_WAIT_ALIGN: begin
                        sync_n_q <= sync_all;
                        seen_q   <= seen_d;
                        if (&seen_d) begin
                            state_q  <= S_RUN;
                            linked_q <= 1'b1;
                            to_cnt_q <= '0;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    S_RUN: begin
                        sync_n_q  <= sync_all;
                        win_cnt_q <= win_wrap ? '0 : win_cnt_q + 1'b1;
                        err_cnt_q <= win_wrap ? '0 : err_cnt_d;
                    end
                    S_FAULT: ;
                    default: state_q <= S_IDLE;
                endcase
                if (resync) begin
                    linked_q <= 1'b0;
                    if (retry_max) begin
                        state_q    <= S_FAULT;
                        fault_q    <= 1'b1;
                        link_rst_q <= '1;
                        sync_n_q   <= 1'b1;
                    end else begin
                        retry_q <= retry_q + 1'b1;
                    end
                end
                // entry into RESET_LINKS overrides whatever the state arms above chose
                if (enter_rst) begin
                    state_q    <= S_RESET_LINKS;
                    link_rst_q <= '1;
                    sync_n_q   <= 1'b0;
                    rst_cnt_q  <= '0;
                    to_cnt_q   <= '0;
                    win_cnt_q  <= '0;
                    err_cnt_q  <= '0;
                    seen_q     <= '0;
                end
            end
        end
    end

    assign lmfc_edge_o  = lmfc_q;
    assign link_rst_o   = link_rst_q;
    assign sync_n_out_o = sync_n_q;
    assign linked_o     = linked_q;
    assign fault_o      = fault_q;
    assign sysref_err_o = sysref_err_q;
    assign retry_cnt_o  = retry_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_jesd_link_supervisor.sv
// Directed bench for jesd_link_supervisor: bring-up table plus error, wrap,
// timeout/fault and enable-drop sequences with hand-computed expectations.
module tb_jesd_link_supervisor;

    logic       clk = 1'b0;
    logic       rst, enable, sysref;
    logic [1:0] sync_n, aligned, err;
    logic       lmfc_edge, sync_n_out, linked, fault, sysref_err;
    logic [1:0] link_rst;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    jesd_link_supervisor #(.NUM_LINKS(2), .LMFC_PERIOD(16), .SYSREF_REQ(1'b1), .RST_CYCLES(4),
                           .TIMEOUT(64), .ERR_WINDOW(4096), .ERR_THRESH(8), .MAX_RETRY(15)) dut (
        .clk(clk), .rst(rst), .enable_i(enable), .sysref_i(sysref),
        .link_sync_n_i(sync_n), .link_aligned_i(aligned), .link_err_i(err),
        .lmfc_edge_o(lmfc_edge), .link_rst_o(link_rst), .sync_n_out_o(sync_n_out),
        .linked_o(linked), .fault_o(fault), .sysref_err_o(sysref_err),
        .retry_cnt_o(retry_cnt), .state_o(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, sr;
        logic [1:0] sn, al, er;
        logic [2:0] st;
        logic [1:0] lr;
        logic       sno, lk, lm, se;
        logic [3:0] rc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic sr, logic [1:0] sn, logic [1:0] al, logic [1:0] er,
                                logic [2:0] st, logic [1:0] lr, logic sno, logic lk, logic lm,
                                logic se, logic [3:0] rc);
        vec_t v;
        v.en = en; v.sr = sr; v.sn = sn; v.al = al; v.er = er;
        v.st = st; v.lr = lr; v.sno = sno; v.lk = lk; v.lm = lm; v.se = se; v.rc = rc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic en, input logic sr, input logic [1:0] sn,
                         input logic [1:0] al, input logic [1:0] er);
        enable = en; sysref = sr; sync_n = sn; aligned = al; err = er;
    endtask

    initial begin
        int fault_at;

        // bring-up table, one row per clock edge after reset release
        for (int e = 1; e <= 16; e++) vecs.push_back(mk(0,0,2'b00,2'b00,2'b00, 3'd0,2'b11,1,0, e==16, 0, 4'd0));
        for (int e = 17; e <= 36; e++) vecs.push_back(mk(1,0,2'b00,2'b00,2'b00, 3'd1,2'b11,1,0, e==32, 0, 4'd0));
        vecs.push_back(mk(1,1,2'b00,2'b00,2'b00, 3'd2,2'b11,0,0,1,0,4'd0));
        for (int e = 38; e <= 40; e++) vecs.push_back(mk(1,0,2'b00,2'b00,2'b00, 3'd2,2'b11,0,0,0,0,4'd0));
        for (int e = 41; e <= 43; e++) vecs.push_back(mk(1,0,2'b00,2'b00,2'b00, 3'd3,2'b00,0,0,0,0,4'd0));
        vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 3'd4,2'b00,1,0,0,0,4'd0));
        vecs.push_back(mk(1,0,2'b11,2'b01,2'b00, 3'd4,2'b00,1,0,0,0,4'd0));
        for (int e = 46; e <= 49; e++) vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 3'd4,2'b00,1,0,0,0,4'd0));
        vecs.push_back(mk(1,0,2'b11,2'b10,2'b00, 3'd5,2'b00,1,1,0,0,4'd0));
        for (int e = 51; e <= 58; e++) vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 3'd5,2'b00,1,1, e==53, 0, 4'd0));
        vecs.push_back(mk(1,1,2'b11,2'b00,2'b00, 3'd5,2'b00,1,1,1,1,4'd0));
        for (int e = 60; e <= 74; e++) vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 3'd5,2'b00,1,1,0,1,4'd0));
        vecs.push_back(mk(1,1,2'b11,2'b00,2'b00, 3'd5,2'b00,1,1,1,1,4'd0));
        vecs.push_back(mk(1,0,2'b11,2'b00,2'b00, 3'd5,2'b00,1,1,0,1,4'd0));

        rst = 1'b1;
        drive(0, 0, 2'b00, 2'b00, 2'b00);
        repeat (3) step();
        chk("rst.state", state, 3'd0);
        chk("rst.link_rst", link_rst, 2'b11);
        chk("rst.sync_n_out", sync_n_out, 1'b1);
        chk("rst.linked", linked, 1'b0);
        chk("rst.fault", fault, 1'b0);
        chk("rst.sysref_err", sysref_err, 1'b0);
        chk("rst.retry_cnt", retry_cnt, 4'd0);
        chk("rst.lmfc_edge", lmfc_edge, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].sr, vecs[i].sn, vecs[i].al, vecs[i].er);
            step();
            chk($sformatf("r%0d.state", i+1), state, vecs[i].st);
            chk($sformatf("r%0d.link_rst", i+1), link_rst, vecs[i].lr);
            chk($sformatf("r%0d.sync_n_out", i+1), sync_n_out, vecs[i].sno);
            chk($sformatf("r%0d.linked", i+1), linked, vecs[i].lk);
            chk($sformatf("r%0d.lmfc_edge", i+1), lmfc_edge, vecs[i].lm);
            chk($sformatf("r%0d.sysref_err", i+1), sysref_err, vecs[i].se);
            chk($sformatf("r%0d.retry_cnt", i+1), retry_cnt, vecs[i].rc);
        end

        // eight error cycles in one window force a resync
        drive(1, 0, 2'b11, 2'b00, 2'b01);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("err8.run%0d", k), state, 3'd5);
        end
        step();
        chk("err8.state", state, 3'd2);
        chk("err8.retry", retry_cnt, 4'd1);
        chk("err8.linked", linked, 1'b0);
        chk("err8.link_rst", link_rst, 2'b11);
        chk("err8.sync_n_out", sync_n_out, 1'b0);
        chk("err8.sysref_err_kept", sysref_err, 1'b1);

        // re-acquire, both aligners completing in the same cycle
        drive(1, 0, 2'b11, 2'b00, 2'b00);
        repeat (3) step();
        chk("reacq.reset", state, 3'd2);
        step();
        chk("reacq.wait_sync", state, 3'd3);
        chk("reacq.link_rst", link_rst, 2'b00);
        step();
        chk("reacq.wait_align", state, 3'd4);
        drive(1, 0, 2'b11, 2'b11, 2'b00);
        step();
        chk("reacq.run", state, 3'd5);
        chk("reacq.linked", linked, 1'b1);
        chk("reacq.retry", retry_cnt, 4'd1);

        // seven errors, window wrap, seven more: no resync; one more trips it
        drive(1, 0, 2'b11, 2'b00, 2'b01);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("wrapA.run%0d", k), state, 3'd5);
        end
        drive(1, 0, 2'b11, 2'b00, 2'b00);
        repeat (4089) step();
        chk("wrap.idle_run", state, 3'd5);
        drive(1, 0, 2'b11, 2'b00, 2'b01);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("wrapB.run%0d", k), state, 3'd5);
        end
        step();
        chk("wrapC.state", state, 3'd2);
        chk("wrapC.retry", retry_cnt, 4'd2);

        // enable drop clears the sticky flags and retry count
        drive(0, 0, 2'b00, 2'b00, 2'b00);
        step();
        chk("dis.state", state, 3'd0);
        chk("dis.retry", retry_cnt, 4'd0);
        chk("dis.sysref_err", sysref_err, 1'b0);
        chk("dis.link_rst", link_rst, 2'b11);
        chk("dis.sync_n_out", sync_n_out, 1'b1);

        drive(1, 0, 2'b00, 2'b00, 2'b00);
        step();
        chk("to.wait_sysref", state, 3'd1);
        drive(1, 1, 2'b00, 2'b00, 2'b00);
        step();
        chk("to.reset", state, 3'd2);
        drive(1, 0, 2'b00, 2'b00, 2'b00);

        // 16 WAIT_SYNC timeouts of 64 cycles, 68 edges per attempt, then FAULT
        fault_at = -1;
        for (int j = 1; j <= 1200; j++) begin
            step();
            if (j == 67) chk("to.first_last_wait", state, 3'd3);
            if (j == 68) begin
                chk("to.first_resync", state, 3'd2);
                chk("to.first_retry", retry_cnt, 4'd1);
            end
            if (state == 3'd6) begin
                fault_at = j;
                break;
            end
        end
        chk("to.fault_edge", fault_at, 1088);
        chk("to.fault", fault, 1'b1);
        chk("to.retry", retry_cnt, 4'd15);
        chk("to.link_rst", link_rst, 2'b11);
        chk("to.sync_n_out", sync_n_out, 1'b1);
        repeat (5) step();
        chk("fault.held", state, 3'd6);

        drive(0, 0, 2'b00, 2'b00, 2'b00);
        step();
        chk("clr.state", state, 3'd0);
        chk("clr.fault", fault, 1'b0);
        chk("clr.retry", retry_cnt, 4'd0);
        drive(1, 0, 2'b00, 2'b00, 2'b00);
        step();
        chk("clr.restart", state, 3'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
